axis_tx_sched: RTL
==================

Name: axis_tx_sched

Overview:
- Packet scheduler that shares one AXI-Stream master port between NUM_REQ requesters.
- Each requester raises a send request with a beat count; the scheduler grants one requester at a time using round-robin.
- It drives tvalid/tdata/tlast for the granted requester's whole packet, then returns to arbitration.
- Sits between producer blocks and the AXI-Stream slave, replacing per-producer masters.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 32, tdata width
- LEN_W, 8, width of per-requester beat count

Ports:
- aclk  in  1  clock
- areset_n  in  1  reset, asynchronous, active-low
- req  in  NUM_REQ  per-requester send request, level
- req_data  in  NUM_REQ*DATA_W  per-requester current beat data; slice i = bits [i*DATA_W +: DATA_W]
- req_len  in  NUM_REQ*LEN_W  per-requester packet length in beats; value 0 treated as 1
- gnt  out  NUM_REQ  one-hot grant, high for the whole packet
- beat_ack  out  NUM_REQ  pulse on the granted bit for each accepted beat (tvalid&tready)
- done  out  NUM_REQ  pulse on the granted bit with the final accepted beat
- tready  in  1  AXI-Stream ready from slave
- tvalid  out  1  AXI-Stream valid
- tdata  out  DATA_W  AXI-Stream data
- tlast  out  1  AXI-Stream last
- tid  out  $clog2(NUM_REQ)  index of the granted requester
- busy  out  1  high in SEND

Behaviour:
- Reset (areset_n=0, async): state=IDLE; gnt=0; tvalid=0; tlast=0; tid=0; busy=0; beat counter=0; round-robin pointer=NUM_REQ-1, so requester 0 wins first.
- Reset mid-packet: tvalid drops immediately; the packet is abandoned with no done pulse.
- FSM has two states, IDLE and SEND.
- IDLE:
  - If any req bit is set, select the first set bit searching upward from pointer+1 with wrap-around.
  - On that edge, register gnt/tid, latch len = max(req_len[sel],1), clear the beat counter, set pointer=sel, and go to SEND.
  - Latency from req rising to tvalid is one cycle.
- SEND:
  - tvalid=1, busy=1.
  - tdata = req_data slice of tid, combinational from the granted requester. The requester must hold data stable until beat_ack.
  - tlast = (count == len-1).
  - On tvalid&tready: beat_ack[tid]=1 and count increments. If tlast, done[tid]=1 in the same cycle, and next state is IDLE with gnt=0 and tvalid=0.
- Inter-packet gap: at least one idle cycle between packets. tvalid is low for one cycle after each tlast handshake.
- AXI rules: once tvalid rises it stays high until the handshake, and tlast/tid are stable while tvalid&!tready.
- req is sampled only in IDLE. Deasserting req during SEND is ignored and the packet completes. req_len changes during SEND are ignored.
- Simultaneous requests are resolved by round-robin only. A requester holding req after done is re-granted only after every other active requester has been served.
- Counter width is LEN_W. Maximum packet is 2^LEN_W-1 beats; no wrap occurs because len is latched.

Optional Feature:
- Macro AXIS_SCHED_PRIO_EN.
- When defined: requester 0 is high priority. In IDLE, if req[0]=1 it wins regardless of the pointer, and the pointer is not updated by a requester-0 grant. All other requesters stay round-robin.
- When undefined: pure round-robin as described above.

Test Plan:
- Single packet: req[1]=1, req_len[1]=3, tready=1 constant -> gnt=4'b0010 one cycle later; three beats with tdata=req_data[1]; tlast on the 3rd beat; done[1] pulses with the 3rd beat; tvalid low the next cycle.
- Backpressure: req[0]=1, len=2, data 32'haaaa_bbbb then 32'hcccc_dddd; tready low for 5 cycles, then pulsed -> tvalid/tdata/tlast held stable while stalled; exactly 2 beat_ack pulses; tlast only on the 32'hcccc_dddd beat.
- Fairness: req=4'b1111 held, all len=1, tready=1 -> grant order 0,1,2,3,0 with one idle cycle between grants.
- Zero length: req[2]=1, req_len[2]=0 -> single beat with tlast=1 and done[2]=1.
- Reset mid-packet: assert areset_n=0 on the 2nd beat of a 4-beat packet -> tvalid/gnt go to 0 asynchronously; after release, next grant goes to requester 0 if requesting.
- With AXIS_SCHED_PRIO_EN: req=4'b0101 held, len=1 -> requester 0 granted every packet and requester 2 starves. Without the macro: grants alternate 0,2,0,2.

Source files
------------

// File: rtl/axis_tx_sched.sv
// Round-robin packet scheduler sharing one AXI-Stream master port between NUM_REQ requesters.
// Define AXIS_SCHED_PRIO_EN to give requester 0 strict priority over the round-robin ring.
module axis_tx_sched #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32,
   parameter int LEN_W   = 8,
   localparam int ID_W   = $clog2(NUM_REQ)
) (
   input  logic                       aclk,
   input  logic                       areset_n,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*DATA_W-1:0]  req_data,
   input  logic [NUM_REQ*LEN_W-1:0]   req_len,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [NUM_REQ-1:0]         beat_ack,
   output logic [NUM_REQ-1:0]         done,
   input  logic                       tready,
   output logic                       tvalid,
   output logic [DATA_W-1:0]          tdata,
   output logic                       tlast,
   output logic [ID_W-1:0]            tid,
   output logic                       busy
);

   typedef enum logic {IDLE, SEND} state_t;

   state_t            state;
   logic [ID_W-1:0]   ptr;
   logic [LEN_W-1:0]  len;
   logic [LEN_W-1:0]  count;
   logic [LEN_W-1:0]  count_nxt;

   logic              arb_found;
   logic              arb_rr;
   logic [ID_W-1:0]   arb_sel;
   logic [ID_W-1:0]   idx;
   logic [LEN_W-1:0]  sel_len;
   logic [LEN_W-1:0]  len_eff;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no latch is inferred.
      arb_found = 1'b0;
      arb_sel   = '0;
      idx       = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = ID_W'((int'(ptr) + k) % NUM_REQ);
         if (!arb_found && req[idx]) begin
            arb_found = 1'b1;
            arb_sel   = idx;
         end
      end
`ifdef AXIS_SCHED_PRIO_EN
      // Requester 0 bypasses the ring and leaves the pointer where it was.
      arb_rr = 1'b1;
      if (req[0]) begin
         arb_found = 1'b1;
         arb_sel   = '0;
         arb_rr    = 1'b0;
      end
`else
      arb_rr = 1'b1;
`endif
   end

   assign sel_len   = req_len[arb_sel*LEN_W +: LEN_W];
   assign len_eff   = (sel_len == '0) ? LEN_W'(1) : sel_len;
   assign count_nxt = count + 1'b1;

   assign tdata    = req_data[tid*DATA_W +: DATA_W];
   assign beat_ack = gnt & {NUM_REQ{tvalid & tready}};
   assign done     = gnt & {NUM_REQ{tvalid & tready & tlast}};

   // NOTE: state registers use non-blocking assignments so all updates take effect together at the edge.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         state  <= IDLE;
         gnt    <= '0;
         tid    <= '0;
         len    <= '0;
         count  <= '0;
         ptr    <= ID_W'(NUM_REQ - 1);
         tvalid <= 1'b0;
         tlast  <= 1'b0;
         busy   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (arb_found) begin
                  gnt    <= NUM_REQ'(1) << arb_sel;
                  tid    <= arb_sel;
                  len    <= len_eff;
                  count  <= '0;
                  if (arb_rr) ptr <= arb_sel;
                  tvalid <= 1'b1;
                  tlast  <= (len_eff == LEN_W'(1));
                  busy   <= 1'b1;
                  state  <= SEND;
               end
            end
            SEND: begin
               if (tready) begin
                  count <= count_nxt;
                  if (tlast) begin
                     gnt    <= '0;
                     tvalid <= 1'b0;
                     tlast  <= 1'b0;
                     busy   <= 1'b0;
                     state  <= IDLE;
                  end else begin
                     // tlast is precomputed for the next beat so it stays registered.
                     tlast <= (count_nxt == len - 1'b1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
